// File: rtl/divider_ctrl.sv
// divider_ctrl: runtime-programmable clock divider with glitch-free ratio changes.
//
// One shared down-counter produces clk_out (high H = D - D/2, low L = D/2
// clk_in cycles) and a one-cycle tick at the start of every high phase.
// New divisors arrive over a valid/ready handshake. In IDLE they apply at
// once; while running they wait in a shadow register until the next
// low->high boundary.
//
// Optional feature macro: DIVCTRL_ODD_EN
//   defined   - odd divisors are honoured (D = 5 -> H = 3, L = 2)
//   undefined - cfg_div[0] (and DEFAULT_DIV[0]) is forced to 0, 50% duty only
//
// Ports
//   clk_in     in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   1 = run, 0 = stop at the end of the current period
//   cfg_valid  in   divisor offered on cfg_div
//   cfg_ready  out  divisor can be accepted this cycle
//   cfg_div    in   requested divisor (clk_in cycles per clk_out period)
//   clk_out    out  divided clock (registered)
//   tick       out  pulse in the first cycle of each high phase
//   busy       out  controller not in IDLE
//   cur_div    out  active divisor after masking and clamping
module divider_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] cur_div
);

    function automatic logic [WIDTH-1:0] sanitize(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] m;
        m = d;
`ifndef DIVCTRL_ODD_EN
        m[0] = 1'b0;
`endif
        if (m < WIDTH'(2)) m = WIDTH'(2);
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] hi_len(input logic [WIDTH-1:0] d);
        return d - (d >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] lo_len(input logic [WIDTH-1:0] d);
        return d >> 1;
    endfunction

    localparam logic [WIDTH-1:0] RESET_DIV = sanitize(WIDTH'(DEFAULT_DIV));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic             pending;

    logic             xfer;
    logic             period_end;
    logic [WIDTH-1:0] cfg_san;
    logic [WIDTH-1:0] idle_div;
    logic [WIDTH-1:0] next_div;

    always_comb begin
        xfer       = cfg_valid && cfg_ready;
        period_end = (cnt == '0) && !clk_out;
        cfg_san    = sanitize(cfg_div);
        // IDLE start on the same edge as a transfer uses the new divisor
        idle_div   = xfer ? cfg_san : cur_div;
        next_div   = pending ? shadow : cur_div;
    end

    // State register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = DRAIN;
            DRAIN: begin
                if (en)              state_nxt = RUN;
                else if (period_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic (both derived from registered state only)
    always_comb begin
        busy      = (state != IDLE);
        cfg_ready = !pending;
    end

    // Counter, divided clock and divisor registers
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
            cnt     <= '0;
            cur_div <= RESET_DIV;
            shadow  <= RESET_DIV;
            pending <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) cur_div <= cfg_san;
                    if (en) begin
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                        cnt     <= hi_len(idle_div) - WIDTH'(1);
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - WIDTH'(1);
                    end else if (clk_out) begin
                        clk_out <= 1'b0;
                        cnt     <= lo_len(cur_div) - WIDTH'(1);
                    end else begin
                        // Period boundary: pending ratio applies here whether
                        // the next period starts or the block goes idle.
                        if (pending) begin
                            cur_div <= shadow;
                            pending <= 1'b0;
                        end
                        if (state == RUN || en) begin
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                            cnt     <= hi_len(next_div) - WIDTH'(1);
                        end
                    end
                    // cfg_ready is low while pending, so this never collides
                    // with the clear above.
                    if (xfer) begin
                        shadow  <= cfg_san;
                        pending <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed self-checking bench for divider_ctrl: reset, basic run, live
// reconfiguration, drain/resume, clamp, odd divisor and async reset.
module tb_divider_ctrl;

    logic        clk_in;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_div;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic [31:0] cur_div;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIVCTRL_ODD_EN
    localparam int unsigned OD = 7;
    localparam int unsigned OH = 4;
`else
    localparam int unsigned OD = 6;
    localparam int unsigned OH = 3;
`endif

    divider_ctrl #(.WIDTH(32), .DEFAULT_DIV(2)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Check cycles [from, to) of a period with high length h; each cycle is
    // checked then advanced. cfg_valid is withdrawn after every edge.
    // pend: a transfer is accepted on the first edge, so cfg_ready is 0 after it.
    task automatic check_cycles(input int h, input int l, input int from, input int to, input bit pend);
        for (int i = from; i < to; i++) begin
            check("clk_out", 32'(clk_out), 32'(i < h));
            check("tick", 32'(tick), 32'(i == 0));
            check("busy", 32'(busy), 32'd1);
            check("cfg_ready", 32'(cfg_ready), 32'(!(pend && i > 0)));
            step();
            cfg_valid = 1'b0;
        end
        if (l < 0) $display("unused");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_cur_div", cur_div, 32'd2);
        @(negedge clk_in);
        rst = 1'b0;

        // Basic run, D = 6
        cfg_valid = 1'b1; cfg_div = 32'd6;
        step();
        cfg_valid = 1'b0;
        check("idle_load_div", cur_div, 32'd6);
        check("idle_ready", 32'(cfg_ready), 32'd1);
        check("idle_clk_out", 32'(clk_out), 32'd0);
        en = 1'b1;
        step();
        check_cycles(3, 3, 0, 6, 0);
        check_cycles(3, 3, 0, 6, 0);

        // Live reconfiguration: 6 -> 8, then 8 -> 4 during the high phase
        cfg_valid = 1'b1; cfg_div = 32'd8;
        check_cycles(3, 3, 0, 6, 1);
        check("reconf_div8", cur_div, 32'd8);
        cfg_valid = 1'b1; cfg_div = 32'd4;
        check_cycles(4, 4, 0, 8, 1);
        check("reconf_div4", cur_div, 32'd4);
        check_cycles(2, 2, 0, 4, 0);
        check_cycles(2, 2, 0, 4, 0);

        // Drain from D = 10
        cfg_valid = 1'b1; cfg_div = 32'd10;
        check_cycles(2, 2, 0, 4, 1);
        check("div10", cur_div, 32'd10);
        en = 1'b0;
        check_cycles(5, 5, 0, 10, 0);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_clk_out", 32'(clk_out), 32'd0);
        check("drain_tick", 32'(tick), 32'd0);
        step();
        check("idle_hold_clk", 32'(clk_out), 32'd0);

        // Resume, then re-raise en during DRAIN
        en = 1'b1;
        step();
        check_cycles(5, 5, 0, 10, 0);
        en = 1'b0;
        check_cycles(5, 5, 0, 3, 0);
        en = 1'b1;
        check_cycles(5, 5, 3, 10, 0);
        check_cycles(5, 5, 0, 10, 0);
        en = 1'b0;
        check_cycles(5, 5, 0, 10, 0);
        check("stop_busy", 32'(busy), 32'd0);

        // Clamp 0 and 1 to 2
        cfg_valid = 1'b1; cfg_div = 32'd0;
        step();
        check("clamp0", cur_div, 32'd2);
        cfg_div = 32'd1;
        step();
        check("clamp1", cur_div, 32'd2);
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        for (int k = 0; k < 3; k++) check_cycles(1, 1, 0, 2, 0);

        // Odd divisor 7
        cfg_valid = 1'b1; cfg_div = 32'd7;
        check_cycles(1, 1, 0, 2, 1);
        check("odd_div", cur_div, 32'(OD));
        check_cycles(OH, 3, 0, OD, 0);
        check_cycles(OH, 3, 0, OD, 0);
        en = 1'b0;
        check_cycles(OH, 3, 0, OD, 0);
        check("odd_stop_busy", 32'(busy), 32'd0);

        // Transfer on the same IDLE edge as en rising
        cfg_valid = 1'b1; cfg_div = 32'd4; en = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("start_xfer_div", cur_div, 32'd4);
        check_cycles(2, 2, 0, 4, 0);

        // Asynchronous reset mid-period with a pending shadow value
        cfg_valid = 1'b1; cfg_div = 32'd10;
        step();
        cfg_valid = 1'b0;
        check("pre_rst_ready", 32'(cfg_ready), 32'd0);
        check("pre_rst_clk", 32'(clk_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_clk_out", 32'(clk_out), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd1);
        check("arst_cur_div", cur_div, 32'd2);
        @(negedge clk_in);
        rst = 1'b0; en = 1'b0;
        step();
        check("post_rst_div", cur_div, 32'd2);
        check("post_rst_clk", 32'(clk_out), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_ctrl.md
# divider_ctrl

Runtime-programmable clock-divider controller for the blink designs. It owns one shared down-counter and produces a divided clock (`clk_out`) plus a one-cycle period tick. Software-side or sequencer logic loads new divide ratios through a valid/ready handshake, and the block applies each new ratio only at a period boundary, so `clk_out` never glitches. It sits between a pattern sequencer (requester) and the LED/output logic, replacing fixed-ratio division wherever the ratio must change at run time.

## Interface
- `WIDTH`, 32: width of the divisor and counter.
- `DEFAULT_DIV`, 2: active divisor after reset; must be ≥ 2.

- `clk_in` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: level; 1 = run the divider, 0 = stop at the next period end.
- `cfg_valid` in 1: a new divisor is offered on `cfg_div`.
- `cfg_ready` out 1: the block can accept a divisor this cycle; reset 1.
- `cfg_div` in WIDTH: requested divisor, in `clk_in` cycles per `clk_out` period.
- `clk_out` out 1: divided clock, registered; reset 0.
- `tick` out 1: one-cycle pulse in the first cycle of each `clk_out` high phase; reset 0.
- `busy` out 1: state ≠ IDLE; reset 0.
- `cur_div` out WIDTH: active divisor after masking and clamping; reset `DEFAULT_DIV`.

## Operation
- **Handshake.** A transfer happens on an edge where `cfg_valid` and `cfg_ready` are both 1.
- **Divisor sanitising.** D is `cfg_div`, LSB masked per Configuration, then clamped to a minimum of 2.
- **Phase lengths.** High phase H = D − D/2 cycles. Low phase L = D/2 cycles. Integer division; period is always H + L.
- **Counter.** WIDTH bits, counts down, and is reloaded with phase length − 1 at each toggle. It never wraps; it is reloaded at 0.
- **IDLE state.**
  - `clk_out` = 0, counter held.
  - A transfer writes `cur_div` directly at that edge. `cfg_ready` stays 1.
  - `en` = 1 at an edge → RUN: `clk_out` ← 1, `tick` ← 1, counter ← H−1.
- **RUN state.**
  - Toggles `clk_out` whenever the counter reaches 0.
  - A transfer latches D into a shadow register and sets the pending flag, so `cfg_ready` = 0.
  - At the low→high toggle, a pending shadow value replaces `cur_div`. The new period uses the new H/L, and the pending flag clears (`cfg_ready` = 1 the next cycle).
  - `en` = 0 → DRAIN.
- **DRAIN state.**
  - Finishes the current period. At the end of the low phase, enters IDLE with `clk_out` = 0, and any pending shadow is applied at that edge.
  - `en` = 1 again → RUN with no gap or extra phase.
- **Simultaneous events.**
  - A transfer and a boundary on the same edge cannot both occur, because `cfg_ready` = 0 while pending.
  - A transfer in IDLE on the same edge as `en` rising: the new D is used for the first period.
- **Reset mid-operation.** All outputs and state return to reset values immediately. The shadow value is discarded.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Start latency.** `en` sampled 1 in IDLE at edge n → `clk_out` = 1 and `tick` = 1 from edge n.
- **Steady state.** `clk_out` is high exactly H cycles and low exactly L cycles. `tick` repeats every D cycles.
- **Reconfiguration latency.** A ratio accepted in RUN takes effect at the next low→high toggle. That is at most one full old period (D_old cycles) later.
- **Stop latency.** After `en` falls, `clk_out` ends low and `busy` falls at the edge that would have started the next period.

## Configuration
- Macro: `DIVCTRL_ODD_EN`.
- **Defined.** Odd divisors are honoured. Example: D = 5 gives H = 3, L = 2.
- **Undefined.** `cfg_div[0]` is forced to 0 before clamping, so only even ratios exist and the duty cycle is exactly 50%. Example: `cfg_div` = 5 gives D = 4.
- `DEFAULT_DIV` is masked the same way.

## Test plan
- **Reset defaults.** Assert `rst` mid-period in RUN → `clk_out` = 0, `tick` = 0, `busy` = 0, `cfg_ready` = 1, and `cur_div` = `DEFAULT_DIV` immediately without waiting for an edge.
- **Basic run.** IDLE, load `cfg_div` = 6, raise `en` → `clk_out` high 3 / low 3 cycles; `tick` every 6 cycles, first on the edge `en` is sampled.
- **Live reconfiguration.** Running D = 8, transfer `cfg_div` = 4 mid-high-phase → `cfg_ready` = 0 until the next rising toggle; the old period completes (4 high + 4 low); then 2 high + 2 low, with `cur_div` = 4 at that edge.
- **Drain and resume.** Drop `en` in the high phase of D = 10 → the period completes and `busy` falls after the 5 low cycles. In a second run, re-raise `en` during DRAIN → the next period starts exactly on schedule.
- **Clamp.** `cfg_div` = 0 and `cfg_div` = 1 → `cur_div` = 2; `clk_out` alternates every cycle.
- **Odd divisor.** `cfg_div` = 7 → with `DIVCTRL_ODD_EN`: high 4 / low 3; without it: `cur_div` = 6, high 3 / low 3.
